// File: rtl/bus_grant_sequencer.sv
// rtl/bus_grant_sequencer.sv - round-robin grant sequencer for an 8-source shared tri-state bus
//
// Purpose:
//   Arbitrates eight bus sources round-robin and drives the select/enable pair
//   of a 3->8 decoder that gates the source output enables. At most one source
//   is granted, each grant is bounded to MAX_HOLD cycles, and TURNAROUND dead
//   cycles separate consecutive owners.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   REQ      in   [7:0] per-source request, bit i = source i
//   RELEASE  in   current owner gives up the bus (ignored with no owner)
//   SEL      out  [2:0] granted source index (decoder A inputs)
//   EN       out  decoder enable, high only while a grant is active
//   GNT      out  [7:0] one-hot grant, (1 << SEL) when EN else 0
//   BUSY     out  high while granting or in the turnaround gap
//   TIMEOUT  out  one-cycle pulse when a grant is revoked by hold expiry

module bus_grant_sequencer #(
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] REQ,
    input  logic       RELEASE,
    output logic [2:0] SEL,
    output logic       EN,
    output logic [7:0] GNT,
    output logic       BUSY,
    output logic       TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam bit         HAS_TURN = (TURNAROUND != 0);
    // The turn counter counts down to zero and arbitration happens on the
    // cycle it reads zero, so loading TURNAROUND-1 yields TURNAROUND dead cycles.
    localparam logic [2:0] TURN_LOAD = 3'(TURNAROUND - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] turn_q, turn_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic       found;
    logic [2:0] winner;
    logic       arb;
    logic       leave;
    logic       expired;

    // Rotating priority search starting at ptr_q. Scanning from the farthest
    // offset down lets the nearest requester overwrite earlier candidates.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (REQ[ptr_q + 3'(k)]) begin
                found  = 1'b1;
                winner = ptr_q + 3'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        turn_d    = turn_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        arb       = 1'b0;
        leave     = RELEASE || !REQ[sel_q] || (hold_q == HOLD_MAX);
        // Expiry only counts when neither higher-priority exit applies.
        expired   = !RELEASE && REQ[sel_q] && (hold_q == HOLD_MAX);

        case (state_q)
            ST_IDLE: begin
                arb = 1'b1;
            end
            ST_GRANT: begin
                if (leave) begin
                    hold_d    = 8'd0;
                    timeout_d = expired;
                    if (HAS_TURN) begin
                        state_d = ST_TURN;
                        turn_d  = TURN_LOAD;
                    end else if (expired) begin
                        // A revoked grant always shows one cycle with EN low so
                        // the TIMEOUT pulse never overlaps an active grant.
                        state_d = ST_IDLE;
                    end else begin
                        arb = 1'b1;
                    end
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_TURN: begin
                if (turn_q == 3'd0) begin
                    arb = 1'b1;
                end else begin
                    turn_d = turn_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arb) begin
            if (found) begin
                state_d = ST_GRANT;
                sel_d   = winner;
                hold_d  = 8'd1;
                ptr_d   = winner + 3'd1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= 3'd0;
            ptr_q     <= 3'd0;
            turn_q    <= 3'd0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            turn_q    <= turn_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign SEL     = sel_q;
    assign EN      = (state_q == ST_GRANT);
    assign GNT     = EN ? (8'b1 << sel_q) : 8'b0;
    assign BUSY    = (state_q != ST_IDLE);
    assign TIMEOUT = timeout_q;

`ifdef FORMAL
    always_comb begin
        assert ($onehot0(GNT));
        assert (GNT == (EN ? (8'b1 << SEL) : 8'b0));
        assert (!EN || (state_q == ST_GRANT));
        assert (hold_q <= HOLD_MAX);
        assert (!TIMEOUT || !EN);
    end
`endif

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// tb/tb_bus_grant_sequencer.sv - self-checking bench for bus_grant_sequencer
module tb_bus_grant_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] req    [4];
    logic       rel    [4];
    logic [2:0] sel_o  [4];
    logic       en_o   [4];
    logic [7:0] gnt_o  [4];
    logic       busy_o [4];
    logic       to_o   [4];

    bus_grant_sequencer #(.MAX_HOLD(16), .TURNAROUND(1)) u0 (
        .clk(clk), .rst(rst), .REQ(req[0]), .RELEASE(rel[0]), .SEL(sel_o[0]),
        .EN(en_o[0]), .GNT(gnt_o[0]), .BUSY(busy_o[0]), .TIMEOUT(to_o[0]));
    bus_grant_sequencer #(.MAX_HOLD(4), .TURNAROUND(1)) u1 (
        .clk(clk), .rst(rst), .REQ(req[1]), .RELEASE(rel[1]), .SEL(sel_o[1]),
        .EN(en_o[1]), .GNT(gnt_o[1]), .BUSY(busy_o[1]), .TIMEOUT(to_o[1]));
    bus_grant_sequencer #(.MAX_HOLD(16), .TURNAROUND(0)) u2 (
        .clk(clk), .rst(rst), .REQ(req[2]), .RELEASE(rel[2]), .SEL(sel_o[2]),
        .EN(en_o[2]), .GNT(gnt_o[2]), .BUSY(busy_o[2]), .TIMEOUT(to_o[2]));
    bus_grant_sequencer #(.MAX_HOLD(16), .TURNAROUND(2)) u3 (
        .clk(clk), .rst(rst), .REQ(req[3]), .RELEASE(rel[3]), .SEL(sel_o[3]),
        .EN(en_o[3]), .GNT(gnt_o[3]), .BUSY(busy_o[3]), .TIMEOUT(to_o[3]));

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    // Model: bus owner (-1 = none), cycles held, remaining dead cycles, pointer.
    int m_owner [4];
    int m_sel   [4];
    int m_hold  [4];
    int m_gap   [4];
    int m_ptr   [4];
    bit m_to    [4];

    function automatic int mh_of(int i);
        return (i == 1) ? 4 : 16;
    endfunction

    function automatic int ta_of(int i);
        case (i)
            2:       return 0;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int pick(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(int i);
        int w;
        bit regrant;
        regrant = 1'b0;
        m_to[i] = 1'b0;
        if (rst) begin
            m_owner[i] = -1; m_sel[i] = 0; m_hold[i] = 0; m_gap[i] = 0; m_ptr[i] = 0;
        end else if (m_owner[i] >= 0) begin
            if (rel[i] || !req[i][m_owner[i]] || m_hold[i] == mh_of(i)) begin
                m_to[i]    = !rel[i] && req[i][m_owner[i]];
                m_owner[i] = -1;
                m_hold[i]  = 0;
                if (ta_of(i) > 0) m_gap[i] = ta_of(i);
                else regrant = !m_to[i];
            end else begin
                m_hold[i]++;
            end
        end else if (m_gap[i] > 1) begin
            m_gap[i]--;
        end else begin
            m_gap[i] = 0;
            regrant  = 1'b1;
        end
        if (regrant) begin
            w = pick(req[i], m_ptr[i]);
            if (w >= 0) begin
                m_owner[i] = w; m_sel[i] = w; m_hold[i] = 1; m_ptr[i] = (w + 1) % 8;
            end
        end
    endtask

    // Inputs change just after posedge, so at negedge they already hold the
    // values the DUT will sample on the next edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("u%0d.EN", i),      en_o[i],   (m_owner[i] >= 0) ? 1 : 0);
                check($sformatf("u%0d.SEL", i),     sel_o[i],  m_sel[i]);
                check($sformatf("u%0d.GNT", i),     gnt_o[i],  (m_owner[i] >= 0) ? (1 << m_sel[i]) : 0);
                check($sformatf("u%0d.BUSY", i),    busy_o[i], (m_owner[i] >= 0 || m_gap[i] > 0) ? 1 : 0);
                check($sformatf("u%0d.TIMEOUT", i), to_o[i],   m_to[i] ? 1 : 0);
            end
        end
        for (int i = 0; i < 4; i++) model_step(i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req[i] = 8'h00;
            rel[i] = 1'b0;
        end
        tick();
        tick();
        rst    = 1'b0;
        chk_on = 1'b1;

        // Idle with no requests
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t1_en", en_o[0], 0);
            check("t1_gnt", gnt_o[0], 8'h00);
            check("t1_sel", sel_o[0], 0);
            check("t1_busy", busy_o[0], 0);
        end

        // Sources 2 and 5 alternate, 3-cycle grants, 1 dead cycle
        req[0] = 8'h24;
        tick();
        for (int g = 0; g < 4; g++) begin
            check("t2_gnt", gnt_o[0], (g % 2 == 0) ? 8'h04 : 8'h20);
            tick();
            tick();
            rel[0] = 1'b1;
            tick();
            rel[0] = 1'b0;
            check("t2_gap_en", en_o[0], 0);
            check("t2_gap_busy", busy_o[0], 1);
            tick();
        end
        check("t2_gnt_last", gnt_o[0], 8'h04);
        req[0] = 8'h00;
        repeat (3) tick();

        // Source 7 held forever, MAX_HOLD=4 timeout and regrant
        req[1] = 8'h80;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t3_en_hold", en_o[1], 1);
            tick();
        end
        check("t3_to_en", en_o[1], 0);
        check("t3_to", to_o[1], 1);
        tick();
        check("t3_regrant_en", en_o[1], 1);
        check("t3_regrant_sel", sel_o[1], 7);
        check("t3_to_clear", to_o[1], 0);
        req[1] = 8'h00;
        tick();
        tick();
        req[1] = 8'h81;
        tick();
        check("t3_ptr_wrap", gnt_o[1], 8'h01);
        req[1] = 8'h00;
        repeat (3) tick();

        // TURNAROUND=0 back-to-back owners
        req[2] = 8'h03;
        tick(); check("t4_g0a", gnt_o[2], 8'h01);
        tick(); check("t4_g0b", gnt_o[2], 8'h01);
        req[2] = 8'h02;
        tick(); check("t4_g1a", gnt_o[2], 8'h02);
        req[2] = 8'h03;
        tick(); check("t4_g1b", gnt_o[2], 8'h02);
        req[2] = 8'h01;
        tick(); check("t4_g0c", gnt_o[2], 8'h01);
        req[2] = 8'h00;
        repeat (3) tick();

        // Reset mid-grant of source 3
        req[0] = 8'h08;
        tick();
        check("t5_gnt3", gnt_o[0], 8'h08);
        req[0] = 8'h09;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        check("t5_rst_en", en_o[0], 0);
        check("t5_rst_gnt", gnt_o[0], 8'h00);
        check("t5_rst_busy", busy_o[0], 0);
        tick();
        check("t5_after_rst", gnt_o[0], 8'h01);
        req[0] = 8'h00;
        repeat (3) tick();

        // All request, 1-cycle grants, TURNAROUND=2
        req[3] = 8'hFF;
        rel[3] = 1'b1;
        for (int g = 0; g < 9; g++) begin
            tick();
            check("t6_en", en_o[3], 1);
            check("t6_sel", sel_o[3], g % 8);
            tick();
            check("t6_dead1", en_o[3], 0);
            check("t6_to1", to_o[3], 0);
            tick();
            check("t6_dead2", en_o[3], 0);
            check("t6_busy2", busy_o[3], 1);
        end
        req[3] = 8'h00;
        rel[3] = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
